// File: rtl/roic_pkg.sv
// Shared constants and types for the ROIC channel framer and its output buffer.
package roic_pkg;

  localparam int ROIC_WORD_W      = 24;
  localparam int DEF_NUM_CH       = 256;
  localparam int DEF_START_OFFSET = 1;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int SKIP_W           = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2
  } framer_state_t;

endpackage

// File: rtl/roic_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is always on rd_data.
module roic_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_ok;
  logic         rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok = rd_en & ~empty;
  // A pop in the same cycle frees the slot being written, so full+pop still accepts.
  assign wr_ok = wr_en & (~full | rd_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/roic_channel_framer.sv
// Frames a detector word stream into indexed channel samples with SOL/EOL tags,
// buffered through an FWFT FIFO behind a valid/ready output.
module roic_channel_framer
  import roic_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int START_OFFSET = DEF_START_OFFSET,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [ROIC_WORD_W-1:0]    word_data_in,
  input  logic                      first_sample_pulse_in,
  output logic [ROIC_WORD_W-1:0]    m_data,
  output logic [$clog2(NUM_CH)-1:0] m_ch_idx,
  output logic                      m_sol,
  output logic                      m_eol,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      overflow_err,
  input  logic                      err_clr,
  output logic                      short_line_err,
  output logic [15:0]               line_count,
  output logic                      busy
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int EW   = ROIC_WORD_W + CH_W + 2;
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [SKIP_W-1:0] SKIP_INI = SKIP_W'(START_OFFSET - 1);

  framer_state_t     state, state_nxt;
  logic [SKIP_W-1:0] skip_cnt, skip_nxt;
  logic [CH_W-1:0]   ch_cnt, ch_nxt;
  logic              cap, abort, line_done;

  logic                   push_vld;
  logic [ROIC_WORD_W-1:0] push_data;
  logic [CH_W-1:0]        push_idx;
  logic                   push_sol;
  logic                   push_eol;

  logic [EW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      skip_cnt <= '0;
      ch_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      ch_cnt   <= ch_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    ch_nxt    = ch_cnt;
    cap       = 1'b0;
    abort     = 1'b0;
    line_done = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      skip_nxt  = '0;
      ch_nxt    = '0;
    end else if (first_sample_pulse_in) begin
      // A line marker always restarts framing; mid-line it also flags the abort.
      abort  = (state != IDLE);
      ch_nxt = '0;
      if (START_OFFSET == 1) begin
        state_nxt = CAPTURE;
        skip_nxt  = '0;
      end else begin
        state_nxt = SKIP;
        skip_nxt  = SKIP_INI;
      end
    end else begin
      case (state)
        SKIP: begin
          skip_nxt = skip_cnt - 1'b1;
          if (skip_cnt == SKIP_W'(1)) state_nxt = CAPTURE;
        end
        CAPTURE: begin
          cap = 1'b1;
          if (ch_cnt == LAST_CH) begin
            line_done = 1'b1;
            state_nxt = IDLE;
            ch_nxt    = '0;
          end else begin
            ch_nxt = ch_cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Captured words are staged one cycle before the FIFO write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push_vld       <= 1'b0;
      push_data      <= '0;
      push_idx       <= '0;
      push_sol       <= 1'b0;
      push_eol       <= 1'b0;
      short_line_err <= 1'b0;
      line_count     <= '0;
    end else begin
      push_vld       <= cap;
      push_data      <= word_data_in;
      push_idx       <= ch_cnt;
      push_sol       <= cap && (ch_cnt == '0);
      push_eol       <= line_done;
      short_line_err <= abort;
      line_count     <= line_count + 16'(line_done);
    end
  end

  assign pop  = m_valid & m_ready;
  assign drop = push_vld & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_n)       overflow_err <= 1'b0;
    else if (drop)    overflow_err <= 1'b1;
    else if (err_clr) overflow_err <= 1'b0;
  end

  roic_sync_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_vld),
    .wr_data ({push_data, push_idx, push_sol, push_eol}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Mask the head when empty so outputs read as zero after reset.
  assign m_valid = ~fifo_empty;
  assign {m_data, m_ch_idx, m_sol, m_eol} = fifo_empty ? '0 : head;
  assign busy = (state != IDLE);

endmodule

// File: doc/roic_channel_framer.md
ROIC_CHANNEL_FRAMER -- requirements
Module: roic_channel_framer

Interface
REQ-001 SHALL have parameter NUM_CH, default 256, channels per ROIC line (2..4096).
REQ-002 SHALL have parameter START_OFFSET, default 1, words from the pulse cycle to channel 0 (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, output buffer entries (power of two, 4..64).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port en, input, 1, framing enable; low forces IDLE at the next edge.
REQ-007 SHALL have port word_data_in, input, 24, word stream from the first-channel detector, one word per clk.
REQ-008 SHALL have port first_sample_pulse_in, input, 1, 1-cycle line-start marker from the detector.
REQ-009 SHALL have port m_data, output, 24, channel sample.
REQ-010 SHALL have port m_ch_idx, output, CH_W=$clog2(NUM_CH), channel index of m_data.
REQ-011 SHALL have ports m_sol and m_eol, output, 1 each, first-channel and last-channel flags.
REQ-012 SHALL have ports m_valid (output, 1) and m_ready (input, 1), the output handshake.
REQ-013 SHALL have ports overflow_err (output, 1, sticky) and err_clr (input, 1, clears it).
REQ-014 SHALL have port short_line_err, output, 1, 1-cycle pulse when a line is aborted.
REQ-015 SHALL have port line_count, output, 16, count of completed lines; wraps 0xFFFF->0.
REQ-016 SHALL have port busy, output, 1, high while the state is not IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, SKIP and CAPTURE.
REQ-018 SHALL, in IDLE with en=1 and first_sample_pulse_in=1, go to SKIP with skip counter = START_OFFSET-1; if START_OFFSET=1, go directly to CAPTURE.
REQ-019 SHALL, in SKIP, decrement the skip counter each cycle and enter CAPTURE when it reaches 0.
REQ-020 SHALL, in CAPTURE, accept word_data_in every cycle as channel ch_cnt (starting at 0); the word on the first CAPTURE cycle is channel 0.
REQ-021 SHALL, at ch_cnt=NUM_CH-1, tag the word m_eol, increment line_count, and return to IDLE; the word with ch_cnt=0 is tagged m_sol.
REQ-022 SHALL, on first_sample_pulse_in in SKIP or CAPTURE, pulse short_line_err, leave line_count unchanged, and restart at REQ-018 in the same cycle; words already buffered remain in the FIFO.
REQ-023 SHALL ignore first_sample_pulse_in while en=0; en falling mid-line aborts without short_line_err.
REQ-024 SHALL push {data, idx, sol, eol} into the FIFO on each CAPTURE word; if the FIFO is full, SHALL drop the word and set overflow_err; the capture counter still advances.
REQ-025 SHALL give the FIFO first-word-fall-through: a word captured at edge t is visible with m_valid=1 after edge t+1.
REQ-026 SHALL pop the FIFO on m_valid & m_ready; a simultaneous push and pop when full SHALL be accepted, with no drop.
REQ-027 SHALL hold m_data/m_ch_idx/m_sol/m_eol stable while m_valid=1 and m_ready=0.
REQ-028 SHALL give err_clr priority below a same-cycle overflow, so overflow_err stays set.

Reset
REQ-029 SHALL, with rst_n=0 at an edge: state=IDLE, counters=0, FIFO empty, m_valid=0, m_data=0, m_ch_idx=0, m_sol=0, m_eol=0, overflow_err=0, short_line_err=0, line_count=0, busy=0.
REQ-030 SHALL, on reset mid-line, discard FIFO contents; the first pulse after release starts a fresh line.

Structure
REQ-031 SHALL take the shared package roic_pkg from the following: ROIC_WORD_W=24, the framer_state_t enum, and default NUM_CH/START_OFFSET/FIFO_DEPTH constants.
REQ-032 SHALL place the FIFO in the sub-module roic_sync_fifo (parameterised width/depth, with full/empty outputs and clk/rst_n).

Verification (NUM_CH=8, START_OFFSET=1, FIFO_DEPTH=16)
REQ-033 SHALL cover this scenario: pulse, then words 0x000100..0x000107 with m_ready=1 -> 8 outputs, idx 0..7, sol on idx0, eol on idx7, line_count=1.
REQ-034 SHALL cover this scenario: pulse, then a second pulse 4 words later -> short_line_err pulse once, 4 partial words output, then a full line idx 0..7, line_count=1.
REQ-035 SHALL cover this scenario: m_ready=0 for three lines (24 words) -> first 16 buffered, overflow_err=1, then m_ready=1 drains 16 in order; err_clr clears the flag.
REQ-036 SHALL cover this scenario: START_OFFSET=3 with pulse and words W0..W9 -> first output is W2 with idx0.
REQ-037 SHALL cover this scenario: rst_n=0 at idx 5 -> all outputs return to reset values next cycle; the next pulse yields idx0 with sol.
REQ-038 SHALL cover this scenario: en=0 with pulses -> no outputs and busy=0; line_count wraps from 0xFFFF to 0 when preloaded via a force.
